// File: rtl/line_raster_engine.sv
// Bresenham line rasteriser: takes one endpoint pair plus colour, writes every in-frame pixel to the frame buffer.
// Latency: first write request 2 cycles after command accept, then one pixel per cycle.
// Backpressure: a presented write holds address/data until I_GPU_READY; clipped pixels take one cycle.
module line_raster_engine #(
    parameter int FB_WIDTH  = 640,
    parameter int FB_HEIGHT = 400,
    parameter int COORD_W   = 10,
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 16
) (
    input  logic               I_CLK,
    input  logic               I_RST,
    input  logic               I_CMD_VALID,
    output logic               O_CMD_READY,
    input  logic [COORD_W-1:0] I_X0,
    input  logic [COORD_W-1:0] I_Y0,
    input  logic [COORD_W-1:0] I_X1,
    input  logic [COORD_W-1:0] I_Y1,
    input  logic [DATA_W-1:0]  I_COLOR,
    output logic [ADDR_W-1:0]  O_GPU_ADDR,
    output logic [DATA_W-1:0]  O_GPU_DATA,
    output logic               O_GPU_WRITE,
    input  logic               I_GPU_READY,
    output logic               O_BUSY,
    output logic               O_DONE,
    output logic [ADDR_W-1:0]  O_PIX_COUNT
);

    localparam int EW = COORD_W + 2;
    localparam logic [31:0]       FB_W_U = FB_WIDTH;
    localparam logic [31:0]       FB_H_U = FB_HEIGHT;
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(FB_WIDTH);

    typedef struct packed {
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic [DATA_W-1:0]  color;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

    state_t state;
    cmd_t   cmd;

    logic [COORD_W-1:0]   x, y;
    logic                 x_dec, y_dec;
    logic signed [EW-1:0] dx, dy, err;

    // Two-stage walk: (x,y) is the next point to emit; the output registers hold the point on the bus.
    logic pt_vld;
    logic out_vld;
    logic out_last;

    logic [COORD_W-1:0]   abs_dx, abs_dy;
    logic signed [EW-1:0] setup_dx, setup_dy;

    assign abs_dx   = (cmd.x1 >= cmd.x0) ? cmd.x1 - cmd.x0 : cmd.x0 - cmd.x1;
    assign abs_dy   = (cmd.y1 >= cmd.y0) ? cmd.y1 - cmd.y0 : cmd.y0 - cmd.y1;
    assign setup_dx = $signed({2'b00, abs_dx});
    assign setup_dy = -$signed({2'b00, abs_dy});

    logic signed [EW:0]   e2, dx_ext, dy_ext;
    logic                 step_x, step_y;
    logic signed [EW-1:0] err_next;
    logic [COORD_W-1:0]   x_next, y_next;

    assign e2     = {err, 1'b0};
    assign dx_ext = {dx[EW-1], dx};
    assign dy_ext = {dy[EW-1], dy};
    assign step_x = (e2 >= dy_ext);
    assign step_y = (e2 <= dx_ext);

    // Both tests use e2 from the old error term.
    always_comb begin
        x_next   = x;
        y_next   = y;
        err_next = err;
        if (step_x) begin
            x_next   = x_dec ? x - COORD_W'(1) : x + COORD_W'(1);
            err_next = err_next + dy;
        end
        if (step_y) begin
            y_next   = y_dec ? y - COORD_W'(1) : y + COORD_W'(1);
            err_next = err_next + dx;
        end
    end

    logic              pt_last;
    logic              pt_in_frame;
    logic [ADDR_W-1:0] pix_addr;
    logic              out_free;
    logic              out_retire;

    assign pt_last     = (x == cmd.x1) && (y == cmd.y1);
    assign pt_in_frame = (32'(x) < FB_W_U) && (32'(y) < FB_H_U);
    assign pix_addr    = ADDR_W'(y) * STRIDE + ADDR_W'(x);

    // A clipped slot (valid but no write request) always frees after one cycle.
    assign out_free   = !out_vld || !O_GPU_WRITE || I_GPU_READY;
    assign out_retire = out_vld && out_free;

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state       <= IDLE;
            cmd         <= '0;
            x           <= '0;
            y           <= '0;
            x_dec       <= 1'b0;
            y_dec       <= 1'b0;
            dx          <= '0;
            dy          <= '0;
            err         <= '0;
            pt_vld      <= 1'b0;
            out_vld     <= 1'b0;
            out_last    <= 1'b0;
            O_CMD_READY <= 1'b1;
            O_GPU_ADDR  <= '0;
            O_GPU_DATA  <= '0;
            O_GPU_WRITE <= 1'b0;
            O_BUSY      <= 1'b0;
            O_DONE      <= 1'b0;
            O_PIX_COUNT <= '0;
        end else begin
            O_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (I_CMD_VALID && O_CMD_READY) begin
                        cmd.x0      <= I_X0;
                        cmd.y0      <= I_Y0;
                        cmd.x1      <= I_X1;
                        cmd.y1      <= I_Y1;
                        cmd.color   <= I_COLOR;
                        O_PIX_COUNT <= '0;
                        O_CMD_READY <= 1'b0;
                        O_BUSY      <= 1'b1;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    x       <= cmd.x0;
                    y       <= cmd.y0;
                    x_dec   <= !(cmd.x0 < cmd.x1);
                    y_dec   <= !(cmd.y0 < cmd.y1);
                    dx      <= setup_dx;
                    dy      <= setup_dy;
                    err     <= setup_dx + setup_dy;
                    pt_vld  <= 1'b1;
                    out_vld <= 1'b0;
                    state   <= DRAW;
                end
                DRAW: begin
                    if (out_vld && O_GPU_WRITE && I_GPU_READY) begin
                        O_PIX_COUNT <= O_PIX_COUNT + ADDR_W'(1);
                    end
                    if (out_retire && out_last) begin
                        out_vld     <= 1'b0;
                        O_GPU_WRITE <= 1'b0;
                        O_DONE      <= 1'b1;
                        state       <= DONE;
                    end else if (out_free) begin
                        if (pt_vld) begin
                            out_vld     <= 1'b1;
                            out_last    <= pt_last;
                            O_GPU_WRITE <= pt_in_frame;
                            O_GPU_ADDR  <= pix_addr;
                            O_GPU_DATA  <= cmd.color;
                            if (pt_last) begin
                                pt_vld <= 1'b0;
                            end else begin
                                x   <= x_next;
                                y   <= y_next;
                                err <= err_next;
                            end
                        end else begin
                            out_vld     <= 1'b0;
                            O_GPU_WRITE <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    O_BUSY      <= 1'b0;
                    O_CMD_READY <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_raster_engine.sv
// Bench for line_raster_engine: integer Bresenham reference, per-cycle write scoreboard, random lines and ready.
module tb_line_raster_engine;
    localparam int FB_WIDTH  = 640;
    localparam int FB_HEIGHT = 400;
    localparam int COORD_W   = 10;
    localparam int ADDR_W    = 18;
    localparam int DATA_W    = 16;

    logic               I_CLK = 1'b0;
    logic               I_RST = 1'b1;
    logic               I_CMD_VALID = 1'b0;
    logic               O_CMD_READY;
    logic [COORD_W-1:0] I_X0 = '0;
    logic [COORD_W-1:0] I_Y0 = '0;
    logic [COORD_W-1:0] I_X1 = '0;
    logic [COORD_W-1:0] I_Y1 = '0;
    logic [DATA_W-1:0]  I_COLOR = '0;
    logic [ADDR_W-1:0]  O_GPU_ADDR;
    logic [DATA_W-1:0]  O_GPU_DATA;
    logic               O_GPU_WRITE;
    logic               I_GPU_READY = 1'b1;
    logic               O_BUSY;
    logic               O_DONE;
    logic [ADDR_W-1:0]  O_PIX_COUNT;

    line_raster_engine #(
        .FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT), .COORD_W(COORD_W),
        .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .I_CLK(I_CLK), .I_RST(I_RST), .I_CMD_VALID(I_CMD_VALID), .O_CMD_READY(O_CMD_READY),
        .I_X0(I_X0), .I_Y0(I_Y0), .I_X1(I_X1), .I_Y1(I_Y1), .I_COLOR(I_COLOR),
        .O_GPU_ADDR(O_GPU_ADDR), .O_GPU_DATA(O_GPU_DATA), .O_GPU_WRITE(O_GPU_WRITE),
        .I_GPU_READY(I_GPU_READY), .O_BUSY(O_BUSY), .O_DONE(O_DONE), .O_PIX_COUNT(O_PIX_COUNT)
    );

    always #5 I_CLK = ~I_CLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge I_CLK) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer Bresenham walk, keeping only in-frame addresses.
    int m_addr[$];
    int m_npts;
    bit m_first_in;

    task automatic model_line(input int x0, input int y0, input int x1, input int y1);
        int x = x0;
        int y = y0;
        int dx = (x1 > x0) ? x1 - x0 : x0 - x1;
        int dy = -((y1 > y0) ? y1 - y0 : y0 - y1);
        int sx = (x0 < x1) ? 1 : -1;
        int sy = (y0 < y1) ? 1 : -1;
        int err = dx + dy;
        int e2;
        m_addr.delete();
        m_npts = 0;
        m_first_in = (x0 < FB_WIDTH) && (y0 < FB_HEIGHT);
        while (m_npts < 5000) begin
            if (x < FB_WIDTH && y < FB_HEIGHT) m_addr.push_back(y * FB_WIDTH + x);
            m_npts++;
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    int               exp_q[$];
    logic [DATA_W-1:0] exp_color;
    int               exp_npts;
    int               exp_cnt;
    bit               exp_first_in;
    bit               chk_lat;
    bit               chk_en = 1'b0;
    int               rdy_mode = 0;

    int                acc_cyc = 0;
    int                done_cnt = 0;
    int                bp_hold_cnt = 0;
    bit                first_pending = 1'b0;
    bit                hold_prev = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [DATA_W-1:0] prev_data = '0;

    // Scoreboard, sampled on the falling edge.
    always @(negedge I_CLK) begin
        if (!chk_en || I_RST) begin
            hold_prev     = 1'b0;
            first_pending = 1'b0;
        end else begin
            if (I_CMD_VALID && O_CMD_READY) begin
                acc_cyc       = cyc;
                first_pending = 1'b1;
            end
            if (hold_prev) begin
                check("hold_write", O_GPU_WRITE, 1);
                check("hold_addr", O_GPU_ADDR, prev_addr);
                check("hold_data", O_GPU_DATA, prev_data);
            end
            if (O_GPU_WRITE) begin
                if (first_pending) begin
                    first_pending = 1'b0;
                    if (chk_lat && exp_first_in) check("first_write_latency", cyc - acc_cyc, 3);
                end
                if (I_GPU_READY) begin
                    check("write_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        check("write_addr", O_GPU_ADDR, exp_q[0]);
                        check("write_data", O_GPU_DATA, exp_color);
                        void'(exp_q.pop_front());
                    end
                end else if (O_GPU_ADDR == 1) begin
                    bp_hold_cnt++;
                end
                hold_prev = !I_GPU_READY;
                prev_addr = O_GPU_ADDR;
                prev_data = O_GPU_DATA;
            end else begin
                hold_prev = 1'b0;
            end
            if (O_DONE) begin
                done_cnt++;
                check("done_all_written", exp_q.size(), 0);
                check("done_pix_count", O_PIX_COUNT, exp_cnt);
                check("done_busy", O_BUSY, 1);
                if (chk_lat) check("done_latency", cyc - acc_cyc, 3 + exp_npts);
            end
        end
    end

    int bp_left = 0;
    bit bp_done = 1'b0;

    always @(posedge I_CLK) begin
        #1;
        if (rdy_mode == 1) begin
            I_GPU_READY = ($urandom_range(0, 3) != 0);
        end else if (rdy_mode == 2) begin
            if (bp_left > 0) begin
                I_GPU_READY = 1'b0;
                bp_left--;
            end else if (!bp_done && O_GPU_WRITE && O_GPU_ADDR == 1) begin
                I_GPU_READY = 1'b0;
                bp_left = 2;
                bp_done = 1'b1;
            end else begin
                I_GPU_READY = 1'b1;
            end
        end else begin
            I_GPU_READY = 1'b1;
            bp_left = 0;
            bp_done = 1'b0;
        end
    end

    task automatic send_cmd(input int x0, input int y0, input int x1, input int y1,
                            input logic [DATA_W-1:0] col);
        bit got = 1'b0;
        @(posedge I_CLK); #2;
        I_X0 = COORD_W'(x0);
        I_Y0 = COORD_W'(y0);
        I_X1 = COORD_W'(x1);
        I_Y1 = COORD_W'(y1);
        I_COLOR = col;
        I_CMD_VALID = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge I_CLK);
            if (O_CMD_READY) got = 1'b1;
        end
        @(posedge I_CLK); #2;
        I_CMD_VALID = 1'b0;
        check("cmd_accepted", got, 1);
    endtask

    task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                            input logic [DATA_W-1:0] col, input int mode);
        int d0;
        int to;
        model_line(x0, y0, x1, y1);
        exp_q = m_addr;
        exp_color = col;
        exp_npts = m_npts;
        exp_cnt = m_addr.size();
        exp_first_in = m_first_in;
        rdy_mode = mode;
        chk_lat = (mode == 0);
        d0 = done_cnt;
        send_cmd(x0, y0, x1, y1, col);
        to = 0;
        while (done_cnt == d0 && to < 4000) begin
            @(negedge I_CLK);
            to++;
        end
        check("done_seen", done_cnt != d0, 1);
        repeat (3) @(negedge I_CLK);
        check("done_single_pulse", done_cnt - d0, 1);
        check("idle_busy", O_BUSY, 0);
        check("idle_ready", O_CMD_READY, 1);
    endtask

    int pin_steep[5] = '{0, 641, 1281, 1922, 2562};
    int pin_rev[4]   = '{3, 2, 1, 0};
    int b0;
    bit got;
    int rx0, ry0, rx1, ry1;

    initial begin
        // Pin the reference against hand-worked lines.
        model_line(0, 0, 2, 4);
        check("model_steep_npts", m_npts, 5);
        for (int i = 0; i < 5; i++) check("model_steep_addr", m_addr[i], pin_steep[i]);
        model_line(3, 0, 0, 0);
        for (int i = 0; i < 4; i++) check("model_rev_addr", m_addr[i], pin_rev[i]);
        model_line(638, 0, 641, 0);
        check("model_clip_npts", m_npts, 4);
        check("model_clip_writes", m_addr.size(), 2);
        check("model_clip_last", m_addr[1], 639);
        model_line(5, 5, 5, 5);
        check("model_point_addr", m_addr[0], 3205);

        I_RST = 1'b1;
        repeat (3) @(posedge I_CLK);
        @(negedge I_CLK);
        check("rst_write", O_GPU_WRITE, 0);
        check("rst_busy", O_BUSY, 0);
        check("rst_done", O_DONE, 0);
        check("rst_pix_count", O_PIX_COUNT, 0);
        check("rst_addr", O_GPU_ADDR, 0);
        check("rst_data", O_GPU_DATA, 0);
        check("rst_ready", O_CMD_READY, 1);
        @(posedge I_CLK); #2;
        I_RST = 1'b0;
        chk_en = 1'b1;

        run_line(0, 0, 3, 0, 16'h0F0F, 0);
        check("horiz_pix_count", O_PIX_COUNT, 4);
        run_line(0, 0, 2, 4, 16'h1234, 0);
        check("steep_pix_count", O_PIX_COUNT, 5);
        run_line(3, 0, 0, 0, 16'hA5A5, 0);
        check("rev_pix_count", O_PIX_COUNT, 4);
        run_line(2, 4, 0, 0, 16'h5A5A, 0);
        check("rev_steep_pix_count", O_PIX_COUNT, 5);

        b0 = bp_hold_cnt;
        run_line(0, 0, 3, 0, 16'hBEEF, 2);
        check("bp_hold_cycles", bp_hold_cnt - b0, 3);
        check("bp_pix_count", O_PIX_COUNT, 4);

        run_line(638, 0, 641, 0, 16'h00FF, 0);
        check("clip_pix_count", O_PIX_COUNT, 2);
        run_line(5, 5, 5, 5, 16'h7777, 0);
        check("point_pix_count", O_PIX_COUNT, 1);

        // Reset while the second pixel of a long line is on the bus.
        chk_en = 1'b0;
        rdy_mode = 0;
        send_cmd(0, 0, 9, 0, 16'h3333);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge I_CLK);
            if (O_GPU_WRITE && O_GPU_ADDR == 1) got = 1'b1;
        end
        check("midrst_reached_pixel2", got, 1);
        I_RST = 1'b1;
        @(negedge I_CLK);
        check("midrst_write", O_GPU_WRITE, 0);
        check("midrst_busy", O_BUSY, 0);
        check("midrst_pix_count", O_PIX_COUNT, 0);
        check("midrst_ready", O_CMD_READY, 1);
        I_RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge I_CLK);
            check("midrst_no_write", O_GPU_WRITE, 0);
        end
        chk_en = 1'b1;
        run_line(4, 7, 8, 9, 16'hC0DE, 0);
        check("after_rst_pix_count", O_PIX_COUNT, 5);

        run_line(700, 450, 0, 0, 16'h4444, 1);

        for (int n = 0; n < 30; n++) begin
            rx0 = $urandom_range(0, 700);
            ry0 = $urandom_range(0, 440);
            rx1 = rx0 + $urandom_range(0, 40) - 20;
            ry1 = ry0 + $urandom_range(0, 40) - 20;
            if (rx1 < 0) rx1 = 0;
            if (ry1 < 0) ry1 = 0;
            run_line(rx0, ry0, rx1, ry1, DATA_W'($urandom_range(0, 65535)), (n % 3 == 0) ? 0 : 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/line_raster_engine.md
Name: line_raster_engine

Overview:
- Parametrised Bresenham line rasteriser; successor to the fixed-slope GPU line drawer.
- Accepts one line command (two endpoints + colour) through a valid/ready handshake.
- Draws all eight octants, including reversed endpoints, into the frame-buffer SRAM.
- Drives the GPU-SRAM write port with backpressure and clips pixels outside the frame.

Parameters:
FB_WIDTH, 640, pixels per row; also the address row stride
FB_HEIGHT, 400, rows in the frame
COORD_W, 10, endpoint coordinate width (unsigned)
ADDR_W, 18, SRAM word address width
DATA_W, 16, pixel colour width

Ports:
I_CLK  in  1  clock; all logic on rising edge
I_RST  in  1  synchronous active-high reset
I_CMD_VALID  in  1  line command present
O_CMD_READY  out  1  engine can accept a command
I_X0  in  COORD_W  start x
I_Y0  in  COORD_W  start y
I_X1  in  COORD_W  end x
I_Y1  in  COORD_W  end y
I_COLOR  in  DATA_W  pixel colour
O_GPU_ADDR  out  ADDR_W  SRAM write address
O_GPU_DATA  out  DATA_W  SRAM write data
O_GPU_WRITE  out  1  write request
I_GPU_READY  in  1  SRAM accepts the write this cycle
O_BUSY  out  1  command in progress
O_DONE  out  1  one-cycle pulse when a line completes
O_PIX_COUNT  out  ADDR_W  pixels written for the last or current line

Behaviour:
- Reset (I_RST high at an edge):
  - Forces IDLE.
  - Clears O_GPU_ADDR, O_GPU_DATA, O_GPU_WRITE, O_BUSY, O_DONE and O_PIX_COUNT to 0.
  - O_CMD_READY is 1 from the first cycle after reset.
  - Reset during DRAW aborts the line; no further writes occur.
- State machine: IDLE -> SETUP -> DRAW -> DONE -> IDLE.
- IDLE:
  - O_CMD_READY=1.
  - A command is accepted when I_CMD_VALID and O_CMD_READY are both high at an edge.
  - On acceptance, latch endpoints and colour, clear O_PIX_COUNT, go to SETUP.
- SETUP (1 cycle):
  - dx=|x1-x0|, dy=-|y1-y0|.
  - sx=+1 if x0<x1 else -1; sy=+1 if y0<y1 else -1.
  - err=dx+dy.
  - Current point (x,y)=(x0,y0).
  - O_BUSY=1 from here until DONE exits.
- Arithmetic widths:
  - err, dx and dy are signed COORD_W+2 bits; no overflow for any legal endpoints.
  - e2=2*err is COORD_W+3 bits.
- DRAW, per pixel:
  - If x<FB_WIDTH and y<FB_HEIGHT:
    - Present O_GPU_WRITE=1, O_GPU_ADDR=y*FB_WIDTH+x, O_GPU_DATA=colour.
    - Hold all three stable until I_GPU_READY=1 at an edge.
    - On that edge, O_PIX_COUNT increments and the engine steps.
  - Otherwise the pixel is clipped: O_GPU_WRITE=0 and the engine steps after one cycle. O_PIX_COUNT does not change.
- Step:
  - If (x,y)==(x1,y1), go to DONE.
  - Else compute e2 from the old err, then apply both tests against that same old err:
    - if e2>=dy: err+=dy, x+=sx.
    - if e2<=dx: err+=dx, y+=sy.
- Throughput and latency:
  - With I_GPU_READY held high, each unclipped pixel takes exactly 1 cycle.
  - The first write is asserted 2 cycles after command acceptance.
- DONE (1 cycle):
  - O_DONE=1, O_GPU_WRITE=0, O_BUSY=0 on exit.
  - O_PIX_COUNT holds until the next command is accepted.
- Degenerate line: x0==x1 and y0==y1 produces exactly one pixel.
- Address multiply is combinational from registered x,y; O_GPU_ADDR is registered.
- I_CMD_VALID is ignored outside IDLE. A command can be accepted in the IDLE cycle right after DONE.
- I_GPU_READY is ignored while O_GPU_WRITE=0.

Test Plan:
- Horizontal line (0,0)->(3,0), colour 0x0F0F, READY=1:
  - Writes to addr 0,1,2,3 on consecutive cycles, starting 2 cycles after acceptance.
  - O_DONE pulses once; O_PIX_COUNT=4.
- Steep line (0,0)->(2,4):
  - Pixels (0,0),(1,1),(1,2),(2,3),(2,4).
  - Addresses 0,641,1281,1922,2562; O_PIX_COUNT=5.
- Reversed line (3,0)->(0,0): addresses 3,2,1,0 in that order. Repeat with (2,4)->(0,0) and confirm the sy=-1 and sx=-1 paths.
- Backpressure, (0,0)->(3,0):
  - Hold READY low for 3 cycles while addr 1 is presented.
  - O_GPU_ADDR=1, O_GPU_DATA and O_GPU_WRITE stay stable for those cycles.
  - No skipped or duplicated pixels; total 4 writes.
- Clipping and single point:
  - (638,0)->(641,0) writes only 638 and 639; O_PIX_COUNT=2; DONE is reached after 4 steps.
  - (5,5)->(5,5) writes one pixel at addr 3205.
- Reset mid-line:
  - Assert I_RST during the 2nd pixel of (0,0)->(9,0).
  - Next cycle: O_GPU_WRITE=0, O_BUSY=0, O_PIX_COUNT=0, O_CMD_READY=1.
  - A new command afterwards draws correctly from its own start point.
